// File: rtl/dcache_pkg.sv
// Shared constants for the D-cache refill controller: FSM encodings and line geometry.
package dcache_pkg;

  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned OFFSET_W       = $clog2(LINE_WORDS_DEF) + 2;

  // Clears the byte-in-line bits of a 32-bit address for the default geometry
  localparam logic [31:0] LINE_BASE_MASK = ~32'((1 << OFFSET_W) - 1);

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WT_REQ  = 3'd1;
  localparam logic [2:0] S_RF_REQ  = 3'd2;
  localparam logic [2:0] S_RF_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

endpackage

// File: rtl/dcache_refill_ctrl_if.sv
// Core-side request/response, memory port and cache fill bundle of the refill controller.
interface dcache_refill_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              request_valid;
  logic              r_valid;
  logic              w_valid;
  logic              hit;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data;
  logic              stall;
  logic              core_resp_valid;
  logic [DATA_W-1:0] core_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              fill_last;

  modport master (
    input  request_valid, r_valid, w_valid, hit, addr, r_data, w_data,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output stall, core_resp_valid, core_rdata,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           fill_valid, fill_addr, fill_data, fill_last
  );

  modport slave (
    output request_valid, r_valid, w_valid, hit, addr, r_data, w_data,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  stall, core_resp_valid, core_rdata,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           fill_valid, fill_addr, fill_data, fill_last
  );

endinterface

// File: rtl/dcache_beat_counter.sv
// Refill beat index within a line; cleared outside the refill wait state.
module dcache_beat_counter #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          clear,
  input  logic                          inc,
  output logic [$clog2(LINE_WORDS)-1:0] beat,
  output logic                          last_c
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);

  always_ff @(posedge CLK) begin
    if (!RESET)     beat <= '0;
    else if (clear) beat <= '0;
    else if (inc)   beat <= beat + BEAT_W'(1);
  end

  assign last_c = (beat == BEAT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/dcache_refill_ctrl.sv
// D-cache miss/response stage: load-hit return, write-through stores, line refill on load miss.
// Optional hit/miss performance counters enabled by DCACHE_PERF_CNT_EN.
module dcache_refill_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  dcache_refill_ctrl_if.master bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_hits,
  output logic [31:0]         perf_misses
`endif
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = BEAT_W + 2;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d;
  logic              cap_req, cap_rdata;
  logic              beat_clr, beat_inc, beat_last;
  logic [BEAT_W-1:0] beat;
  logic              accept;
  logic [ADDR_W-1:0] line_base;

  assign line_base = addr_q & BASE_MASK;
  // Reset gates acceptance so nothing combinational leaks out during reset
  assign accept = RESET && (state_q == S_IDLE) && bus.request_valid
                  && (bus.r_valid || bus.w_valid);

  dcache_beat_counter #(.LINE_WORDS(LINE_WORDS)) u_beat (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (beat_clr),
    .inc    (beat_inc),
    .beat   (beat),
    .last_c (beat_last)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    cap_req             = 1'b0;
    cap_rdata           = 1'b0;
    rdata_d             = '0;
    beat_clr            = 1'b1;
    beat_inc            = 1'b0;
    bus.stall           = 1'b0;
    bus.core_resp_valid = 1'b0;
    bus.core_rdata      = '0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_we      = 1'b0;
    bus.mem_req_addr    = '0;
    bus.mem_req_wdata   = '0;
    bus.fill_valid      = 1'b0;
    bus.fill_addr       = '0;
    bus.fill_data       = '0;
    bus.fill_last       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Store wins when both r_valid and w_valid are set; stores never allocate
          if (bus.w_valid) begin
            bus.stall = 1'b1;
            cap_req   = 1'b1;
            cap_rdata = 1'b1;
            state_d   = S_WT_REQ;
            if (bus.hit) begin
              bus.fill_valid = 1'b1;
              bus.fill_addr  = bus.addr;
              bus.fill_data  = bus.w_data;
            end
          end else if (bus.hit) begin
            cap_rdata = 1'b1;
            rdata_d   = bus.r_data;
            state_d   = S_RESP;
          end else begin
            bus.stall = 1'b1;
            cap_req   = 1'b1;
            state_d   = S_RF_REQ;
          end
        end
      end
      S_WT_REQ: begin
        bus.stall         = 1'b1;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = addr_q;
        bus.mem_req_wdata = wdata_q;
        if (bus.mem_req_ready) state_d = S_RESP;
      end
      S_RF_REQ: begin
        bus.stall         = 1'b1;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = line_base;
        if (bus.mem_req_ready) state_d = S_RF_WAIT;
      end
      S_RF_WAIT: begin
        bus.stall = 1'b1;
        beat_clr  = 1'b0;
        if (bus.mem_resp_valid) begin
          beat_inc       = 1'b1;
          bus.fill_valid = 1'b1;
          bus.fill_data  = bus.mem_resp_data;
          bus.fill_addr  = line_base + ADDR_W'({beat, 2'b00});
          if (beat == addr_q[OFF_W-1:2]) begin
            cap_rdata = 1'b1;
            rdata_d   = bus.mem_resp_data;
          end
          if (beat_last) begin
            bus.fill_last = 1'b1;
            state_d       = S_RESP;
          end
        end
      end
      S_RESP: begin
        bus.core_resp_valid = 1'b1;
        bus.core_rdata      = rdata_q;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request and load-result capture
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (cap_req) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.w_data;
      end
      if (cap_rdata) rdata_q <= rdata_d;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Saturating hit/miss counters over accepted loads and stores
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (accept) begin
      if (bus.hit) begin
        if (perf_hits != 32'hFFFF_FFFF) perf_hits <= perf_hits + 32'd1;
      end else begin
        if (perf_misses != 32'hFFFF_FFFF) perf_misses <= perf_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl; perf-counter steps run when DCACHE_PERF_CNT_EN is defined.
module tb_dcache_refill_ctrl;

  logic CLK;
  logic RESET;
  int   total;
  int   passed;

  dcache_refill_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  dcache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic rv, input logic r, input logic w, input logic h,
                     input logic [31:0] a, input logic [31:0] rd, input logic [31:0] wd);
    bus.request_valid = rv;
    bus.r_valid       = r;
    bus.w_valid       = w;
    bus.hit           = h;
    bus.addr          = a;
    bus.r_data        = rd;
    bus.w_data        = wd;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"},    32'(bus.stall), 32'd0);
    chk({tag, "_resp"},     32'(bus.core_resp_valid), 32'd0);
    chk({tag, "_rdata"},    bus.core_rdata, 32'd0);
    chk({tag, "_memreq"},   32'(bus.mem_req_valid), 32'd0);
    chk({tag, "_memaddr"},  bus.mem_req_addr, 32'd0);
    chk({tag, "_fill"},     32'(bus.fill_valid), 32'd0);
    chk({tag, "_filllast"}, 32'(bus.fill_last), 32'd0);
  endtask

  initial begin
    int b;
    total  = 0;
    passed = 0;
    RESET  = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    repeat (2) tick();
    chk_quiet("reset");
    RESET = 1'b1;
    tick();

    // Load hit: latency 1, never stalls
    req(1, 1, 0, 1, 32'h100, 32'hDEAD_BEEF, 0);
    #1;
    chk("lh_stall", 32'(bus.stall), 32'd0);
    chk("lh_resp_early", 32'(bus.core_resp_valid), 32'd0);
    tick();
    req(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lh_resp", 32'(bus.core_resp_valid), 32'd1);
    chk("lh_rdata", bus.core_rdata, 32'hDEAD_BEEF);
    chk("lh_stall2", 32'(bus.stall), 32'd0);
    tick();
    chk("lh_resp_pulse", 32'(bus.core_resp_valid), 32'd0);

    // Load miss at word offset 2 with one idle gap in the refill
    req(1, 1, 0, 0, 32'h1000_0008, 32'h0, 0);
    #1;
    chk("lm_stall_idle", 32'(bus.stall), 32'd1);
    chk("lm_noreq_idle", 32'(bus.mem_req_valid), 32'd0);
    tick();
    chk("lm_req", 32'(bus.mem_req_valid), 32'd1);
    chk("lm_we", 32'(bus.mem_req_we), 32'd0);
    chk("lm_addr", bus.mem_req_addr, 32'h1000_0000);
    chk("lm_stall_req", 32'(bus.stall), 32'd1);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    b = 0;
    for (int s = 0; s < 5; s++) begin
      if (s == 2) begin
        bus.mem_resp_valid = 1'b0;
        #1;
        chk("lm_gap_fill", 32'(bus.fill_valid), 32'd0);
        chk("lm_gap_stall", 32'(bus.stall), 32'd1);
      end else begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hA0 + 32'(b);
        #1;
        chk("lm_fill", 32'(bus.fill_valid), 32'd1);
        chk("lm_fill_addr", bus.fill_addr, 32'h1000_0000 + 32'(4 * b));
        chk("lm_fill_data", bus.fill_data, 32'hA0 + 32'(b));
        chk("lm_fill_last", 32'(bus.fill_last), (b == 3) ? 32'd1 : 32'd0);
        b++;
      end
      tick();
    end
    bus.mem_resp_valid = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lm_resp", 32'(bus.core_resp_valid), 32'd1);
    chk("lm_rdata", bus.core_rdata, 32'hA2);
    chk("lm_stall_fall", 32'(bus.stall), 32'd0);
    tick();
    chk("lm_resp_pulse", 32'(bus.core_resp_valid), 32'd0);

    // Store miss with memory back-pressure for 3 cycles
    req(1, 0, 1, 0, 32'h200, 0, 32'h55);
    #1;
    chk("sm_stall_idle", 32'(bus.stall), 32'd1);
    chk("sm_nofill_idle", 32'(bus.fill_valid), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sm_req", 32'(bus.mem_req_valid), 32'd1);
      chk("sm_we", 32'(bus.mem_req_we), 32'd1);
      chk("sm_addr", bus.mem_req_addr, 32'h200);
      chk("sm_wdata", bus.mem_req_wdata, 32'h55);
      chk("sm_nofill", 32'(bus.fill_valid), 32'd0);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    #1;
    chk("sm_req4", 32'(bus.mem_req_valid), 32'd1);
    chk("sm_addr4", bus.mem_req_addr, 32'h200);
    tick();
    bus.mem_req_ready = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sm_resp", 32'(bus.core_resp_valid), 32'd1);
    chk("sm_rdata", bus.core_rdata, 32'd0);
    chk("sm_req_done", 32'(bus.mem_req_valid), 32'd0);
    tick();

    // Store hit: same-cycle array write, then write-through
    req(1, 0, 1, 1, 32'h204, 0, 32'h1234);
    #1;
    chk("sh_fill", 32'(bus.fill_valid), 32'd1);
    chk("sh_fill_data", bus.fill_data, 32'h1234);
    chk("sh_fill_addr", bus.fill_addr, 32'h204);
    chk("sh_fill_last", 32'(bus.fill_last), 32'd0);
    chk("sh_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("sh_req", 32'(bus.mem_req_valid), 32'd1);
    chk("sh_we", 32'(bus.mem_req_we), 32'd1);
    chk("sh_addr", bus.mem_req_addr, 32'h204);
    chk("sh_wdata", bus.mem_req_wdata, 32'h1234);
    chk("sh_fill_once", 32'(bus.fill_valid), 32'd0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sh_resp", 32'(bus.core_resp_valid), 32'd1);
    tick();

    // Load and store together is a store
    req(1, 1, 1, 0, 32'h400, 32'h77, 32'h99);
    tick();
    chk("rw_we", 32'(bus.mem_req_we), 32'd1);
    chk("rw_wdata", bus.mem_req_wdata, 32'h99);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rw_rdata", bus.core_rdata, 32'd0);
    tick();

    // Stray memory response in IDLE must not fill
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hBAD;
    #1;
    chk("stray_fill", 32'(bus.fill_valid), 32'd0);
    bus.mem_resp_valid = 1'b0;
    tick();

    // Reset in the middle of a refill
    req(1, 1, 0, 0, 32'h300, 0, 0);
    tick();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hB0;
    tick();
    bus.mem_resp_data  = 32'hB1;
    tick();
    RESET = 1'b0;
    bus.mem_resp_valid = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_quiet("midrst");
    RESET = 1'b1;
    tick();
    req(1, 1, 0, 1, 32'h100, 32'hCAFE_F00D, 0);
    tick();
    req(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_resp", 32'(bus.core_resp_valid), 32'd1);
    chk("post_rst_rdata", bus.core_rdata, 32'hCAFE_F00D);
    tick();

`ifdef DCACHE_PERF_CNT_EN
    RESET = 1'b0;
    tick();
    chk("perf_rst_hits", perf_hits, 32'd0);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req(1, 1, 0, 1, 32'h40, 32'h1, 0);
      tick();
      req(0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      req(1, 0, 1, 0, 32'h80, 0, 32'h2);
      bus.mem_req_ready = 1'b1;
      tick();
      tick();
      req(0, 0, 0, 0, 0, 0, 0);
      bus.mem_req_ready = 1'b0;
      tick();
    end
    chk("perf_hits", perf_hits, 32'd3);
    chk("perf_misses", perf_misses, 32'd2);
    force dut.perf_hits = 32'hFFFF_FFFF;
    #1;
    release dut.perf_hits;
    req(1, 1, 0, 1, 32'h40, 32'h1, 0);
    tick();
    req(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("perf_sat", perf_hits, 32'hFFFF_FFFF);
    chk("perf_misses_hold", perf_misses, 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
